partial_sort_ctrl: RTL and testbench
====================================

# partial_sort_ctrl

Sequencer that collects a batch of N signed 16-bit samples, sorts them in place with a single shared `compare_swap_asc` instance using odd-even transposition, then streams out the K smallest values in ascending order. It sits between the sample source and the downstream consumer of the partial-sort result. It trades throughput for area: one compare-swap evaluation per clock.

## Interface
- `N`, default 8: batch size; even, ≥ 2.
- `K`, default 4: number of outputs per batch; 1 ≤ K ≤ N.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block accepts input this cycle.
- `in_data`  in  16: signed sample.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts output this cycle.
- `out_data`  out  16: signed result, ascending order.
- `out_last`  out  1: marks the K-th (final) output beat of the batch.
- `busy`  out  1: high in SORT or DRAIN.

## Operation
- FSM states:
  - LOAD → SORT when the N-th sample is accepted.
  - SORT → DRAIN after the final compare.
  - DRAIN → LOAD when the K-th output is accepted.
- Reset:
  - Enters LOAD with load count 0, phase 0, pair index 0 and all buffer entries 0.
  - Outputs while `rst` is high: `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid & in_ready` beat writes `buf[cnt]` and increments `cnt`. Samples are stored in arrival order.
  - Gaps in `in_valid` are allowed.
- SORT:
  - Runs N phases, p = 0..N-1.
  - Even p compares pairs (0,1), (2,3), …, (N-2,N-1): N/2 cycles.
  - Odd p compares pairs (1,2), …, (N-3,N-2): N/2-1 cycles.
  - Each cycle feeds `buf[i]` and `buf[i+1]` to `compare_swap_asc`, then writes min to `buf[i]` and max to `buf[i+1]` at the edge.
  - Total SORT cycles are N/2·(N-1), which is 28 for N=8.
  - There is no early termination; the cycle count is data-independent.
- Comparison semantics:
  - The comparison is signed; -32768 is the smallest value.
  - Ties leave values unchanged.
- DRAIN:
  - `out_valid`=1 and `out_data`=`buf[idx]`, with idx starting at 0.
  - Each `out_valid & out_ready` beat increments idx.
  - `out_last`=1 when idx = K-1.
  - While stalled, `out_data` and `out_last` hold.
- `in_ready`=0 in SORT and DRAIN; input beats offered then are not consumed.
- Reset mid-operation:
  - Abandons the batch immediately.
  - No partial output follows reset.
  - The next batch starts from `cnt`=0.

## Timing
- Load throughput is one sample per cycle.
- Latency:
  - The edge that accepts the N-th sample moves the FSM to SORT.
  - Exactly N/2·(N-1) further edges later, the FSM is in DRAIN and `out_valid` is high in the following cycle.
- Drain throughput is one beat per cycle while `out_ready`=1.
- After the K-th beat is accepted, `in_ready`=1 in the very next cycle, so back-to-back batches are supported.
- Minimum cycles per batch: N + N/2·(N-1) + K.
- All outputs are decoded from registered state, with no combinational path from inputs to outputs.

## Structure
- Package `partial_sort_pkg` holds:
  - the state enum (LOAD, SORT, DRAIN);
  - `DATA_W` = 16;
  - a constant function returning the SORT cycle count for a given N.
- The datapath instantiates exactly one `compare_swap_asc`; it is the only comparator.
- Counters:
  - `cnt`: $clog2(N+1) bits;
  - phase `p`: $clog2(N) bits;
  - pair index `i`;
  - output `idx`: $clog2(K) bits.
- No further sub-modules.

## Test plan
All scenarios use N=8, K=4.

1. Mixed values: load 5, -3, 7, 0, -32768, 32767, 2, 2 → outputs -32768, -3, 0, 2, with `out_last` on 2.
2. Latency: load 0..7 already sorted → outputs 0, 1, 2, 3. The first `out_valid` appears exactly 28 edges after the last input accept.
3. Worst case: load 7, 6, …, 0 (reversed) → outputs 0, 1, 2, 3, with `busy` high for 28 + 4 cycles at `out_ready`=1.
4. Backpressure: toggle `out_ready` pseudo-randomly during DRAIN and hold `in_valid`=1 throughout SORT/DRAIN → no duplicated or dropped beats, and `in_ready`=0 until the 4th beat is accepted.
5. Reset mid-sort: assert `rst` at SORT cycle 10 → `out_valid`=0 and `busy`=0 immediately. After release, batch -1 ×8 yields -1, -1, -1, -1.
6. Back-to-back batches with random `in_valid` gaps → every batch matches a reference sort of its 8 inputs, first 4 values.

Source files
------------

// File: rtl/partial_sort_pkg.sv
// Shared types and constants for the partial-sort sequencer.
package partial_sort_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Odd-even transposition over n entries: n phases alternating n/2 and n/2-1 compares.
  function automatic int sort_cycles(input int n);
    return (n / 2) * (n - 1);
  endfunction

endpackage

// File: rtl/compare_swap_asc.sv
// Signed ascending compare-swap; equal inputs pass through unchanged.
module compare_swap_asc
  import partial_sort_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] lo,
  output logic signed [DATA_W-1:0] hi
);

  logic swap;

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/partial_sort_ctrl.sv
// Collects N samples, sorts them in place one compare-swap per clock,
// then streams the K smallest in ascending order.
module partial_sort_ctrl
  import partial_sort_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int C_W = $clog2(N + 1);
  localparam int P_W = $clog2(N);
  localparam int I_W = $clog2(N);
  localparam int X_W = (K > 1) ? $clog2(K) : 1;

  // With N=2 the odd phase is empty, so sorting ends after phase 0.
  localparam logic [P_W-1:0] LAST_P   = P_W'((N > 2) ? N - 1 : 0);
  localparam logic [I_W-1:0] EVEN_END = I_W'(N - 2);
  localparam logic [I_W-1:0] ODD_END  = I_W'((N > 2) ? N - 3 : 0);
  localparam logic [C_W-1:0] CNT_LAST = C_W'(N - 1);
  localparam logic [X_W-1:0] IDX_LAST = X_W'(K - 1);

  state_t state_reg, state_next;

  logic [C_W-1:0] cnt_reg;
  logic [P_W-1:0] p_reg;
  logic [I_W-1:0] i_reg;
  logic [X_W-1:0] idx_reg;
  logic           in_ready_reg;

  logic signed [DATA_W-1:0] buf_reg [N];

  logic load_fire, sort_en, out_fire, phase_end, sort_done;
  logic signed [DATA_W-1:0] cs_a, cs_b, cs_lo, cs_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= LOAD;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_fire  = 1'b0;
    sort_en    = 1'b0;
    out_fire   = 1'b0;
    phase_end  = p_reg[0] ? (i_reg == ODD_END) : (i_reg == EVEN_END);
    sort_done  = (p_reg == LAST_P) && phase_end;
    case (state_reg)
      LOAD: begin
        load_fire = in_valid && in_ready_reg;
        if (load_fire && (cnt_reg == CNT_LAST)) state_next = SORT;
      end
      SORT: begin
        sort_en = 1'b1;
        if (sort_done) state_next = DRAIN;
      end
      DRAIN: begin
        out_fire = out_ready;
        if (out_fire && (idx_reg == IDX_LAST)) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Registered so that in_ready stays low while reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready_reg <= 1'b0;
    else     in_ready_reg <= (state_next == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      p_reg   <= '0;
      i_reg   <= '0;
      idx_reg <= '0;
    end else begin
      if (load_fire)
        cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + C_W'(1);
      if (sort_en) begin
        if (phase_end) begin
          p_reg <= sort_done ? '0 : p_reg + P_W'(1);
          i_reg <= (p_reg[0] || sort_done) ? '0 : I_W'(1);
        end else begin
          i_reg <= i_reg + I_W'(2);
        end
      end
      if (out_fire)
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + X_W'(1);
    end
  end

  assign cs_a = buf_reg[i_reg];
  assign cs_b = buf_reg[i_reg + I_W'(1)];

  compare_swap_asc u_cswap (
    .a  (cs_a),
    .b  (cs_b),
    .lo (cs_lo),
    .hi (cs_hi)
  );

  // Each entry is written by the loader, or as the low/high side of the active pair.
  for (genvar gi = 0; gi < N; gi++) begin : g_buf
    logic wr_in, wr_lo, wr_hi;
    assign wr_in = load_fire && (cnt_reg == C_W'(gi));
    assign wr_lo = sort_en && (i_reg == I_W'(gi));
    if (gi > 0) begin : g_hi
      assign wr_hi = sort_en && (i_reg == I_W'(gi - 1));
    end else begin : g_nohi
      assign wr_hi = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)        buf_reg[gi] <= '0;
      else if (wr_in) buf_reg[gi] <= in_data;
      else if (wr_lo) buf_reg[gi] <= cs_lo;
      else if (wr_hi) buf_reg[gi] <= cs_hi;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg == DRAIN);
  assign out_last  = out_valid && (idx_reg == IDX_LAST);
  assign out_data  = buf_reg[I_W'(idx_reg)];
  assign busy      = (state_reg != LOAD);

endmodule

// File: tb/tb_partial_sort_ctrl.sv
// Randomized bench for partial_sort_ctrl against a plain sort-and-take-K model.
module tb_partial_sort_ctrl;

  localparam int N = 8;
  localparam int K = 4;
  localparam int SORT_CYC = (N / 2) * (N - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy;
  logic signed [15:0] out_data;

  int checks = 0;
  int errors = 0;
  int batch [N];
  int expv [K];
  int bc, lat;

  always #5 clk = ~clk;

  partial_sort_ctrl #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: full insertion sort of the batch, keep the K smallest.
  task automatic build_expected();
    int s [N];
    int t;
    for (int a = 0; a < N; a++) s[a] = batch[a];
    for (int a = 1; a < N; a++) begin
      t = s[a];
      for (int b = a - 1; b >= 0 && s[b] > t; b--) begin
        s[b + 1] = s[b];
        s[b] = t;
      end
    end
    for (int a = 0; a < K; a++) expv[a] = s[a];
  endtask

  task automatic random_batch();
    logic signed [15:0] t;
    for (int j = 0; j < N; j++) begin
      case ($urandom_range(0, 5))
        0:       batch[j] = -32768;
        1:       batch[j] = 32767;
        2:       batch[j] = int'($urandom_range(0, 4)) - 2;
        default: begin t = 16'($urandom); batch[j] = int'(t); end
      endcase
    end
  endtask

  task automatic push(input int v, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = 16'(v);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("in  sample %0d", v);
  endtask

  task automatic load_batch(input int maxgap);
    build_expected();
    for (int j = 0; j < N; j++)
      push(batch[j], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  // Called right after the last input accept; lat counts edges to first out_valid.
  task automatic drain(input bit rnd_ready, input bit hold_in, output int busy_cnt, output int lat_o);
    int n, cyc, ir_bad, held_data, held_last;
    bit held;
    n = 0; cyc = 0; ir_bad = 0; held = 1'b0; held_data = 0; held_last = 0;
    busy_cnt = 0; lat_o = -1;
    if (hold_in) begin in_valid = 1'b1; in_data = 16'($urandom); end
    while (n < K && cyc < 400) begin
      out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (busy) busy_cnt++;
      if (in_ready) ir_bad++;
      if (out_valid) begin
        if (lat_o < 0) lat_o = cyc;
        if (held) begin
          chk("stall_data", int'(out_data), held_data);
          chk("stall_last", int'(out_last), held_last);
        end
        if (out_ready) begin
          $display("out beat %0d data %0d last %0d", n, out_data, out_last);
          chk($sformatf("beat%0d_data", n), int'(out_data), expv[n]);
          chk($sformatf("beat%0d_last", n), int'(out_last), (n == K - 1) ? 1 : 0);
          n++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_data = int'(out_data);
          held_last = int'(out_last);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("drain_beats", n, K);
    chk("in_ready_low", ir_bad, 0);
    chk("in_ready_next", int'(in_ready), 1);
    chk("busy_clear", int'(busy), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Mixed values including both extremes and a tie
    batch = '{5, -3, 7, 0, -32768, 32767, 2, 2};
    load_batch(0);
    drain(1'b0, 1'b0, bc, lat);
    chk("t1_latency", lat, SORT_CYC);

    // Already sorted: latency
    for (int j = 0; j < N; j++) batch[j] = j;
    load_batch(0);
    drain(1'b0, 1'b0, bc, lat);
    chk("t2_latency", lat, SORT_CYC);

    // Reversed: busy duration
    for (int j = 0; j < N; j++) batch[j] = N - 1 - j;
    load_batch(0);
    drain(1'b0, 1'b0, bc, lat);
    chk("t3_busy_cycles", bc, SORT_CYC + K);

    // Backpressure with in_valid held high through SORT/DRAIN
    random_batch();
    load_batch(0);
    drain(1'b1, 1'b1, bc, lat);
    chk("t4_latency", lat, SORT_CYC);

    // Reset during SORT
    random_batch();
    load_batch(0);
    repeat (10) begin @(posedge clk); #1; end
    chk("t5_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", int'(out_valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_post_out_valid", int'(out_valid), 0);
    for (int j = 0; j < N; j++) batch[j] = -1;
    load_batch(0);
    drain(1'b0, 1'b0, bc, lat);

    // Back-to-back random batches with input gaps and random backpressure
    for (int b = 0; b < 6; b++) begin
      random_batch();
      load_batch(3);
      drain(1'b1, 1'b0, bc, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
